// File: rtl/simplez_harness_pkg.sv
// Shared types and default parameters for the simplez trace harness.
package simplez_harness_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_LAT     = 1;
    localparam int DEF_RST_CYC = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DUTRST = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_DUTRST) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/simplez_trace_harness_if.sv
// Bus between the harness and the design being exercised.
interface simplez_trace_harness_if #(parameter int W = 8) ();
    logic [W-1:0] dut_ui;
    logic         dut_ena;
    logic         dut_rst_n;
    logic [W-1:0] dut_uo;

    modport master (output dut_ui, output dut_ena, output dut_rst_n, input dut_uo);
    modport slave  (input dut_ui, input dut_ena, input dut_rst_n, output dut_uo);
endinterface

// File: rtl/simplez_harness_pipe.sv
// LAT-deep valid/index delay line that lines up each vector with its response.
module simplez_harness_pipe #(
    parameter int LAT = 1,
    parameter int AW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_idx,
    output logic          out_valid,
    output logic [AW-1:0] out_idx
);
    logic [LAT-1:0] vld_r;
    logic [AW-1:0]  idx_r [LAT];

    // Shift valid and index one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= '0;
            for (int k = 0; k < LAT; k++) idx_r[k] <= '0;
        end else begin
            vld_r[0] <= in_valid;
            idx_r[0] <= in_idx;
            for (int k = 1; k < LAT; k++) begin
                vld_r[k] <= vld_r[k-1];
                idx_r[k] <= idx_r[k-1];
            end
        end
    end

    assign out_valid = vld_r[LAT-1];
    assign out_idx   = idx_r[LAT-1];
endmodule

// File: rtl/simplez_trace_harness.sv
// Vector playback harness: resets a DUT, plays stored stimulus and compares
// masked responses against expected values.
module simplez_trace_harness
    import simplez_harness_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LAT     = DEF_LAT,
    parameter int RST_CYC = DEF_RST_CYC,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [W-1:0]            cfg_stim,
    input  logic [W-1:0]            cfg_exp,
    input  logic [W-1:0]            cfg_mask,
    input  logic                    start,
    input  logic [AW:0]             len,
    simplez_trace_harness_if.master dut,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [AW:0]             err_count,
    output logic [AW-1:0]           first_err_idx,
    output logic [W-1:0]            first_err_val
);
    localparam int CMAX = (RST_CYC > LAT) ? RST_CYC : LAT;
    localparam int CW   = $clog2(CMAX) + 1;

    logic [W-1:0] stim_mem [DEPTH];
    logic [W-1:0] exp_mem  [DEPTH];
    logic [W-1:0] mask_mem [DEPTH];

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [AW:0]   idx_r, idx_s, len_r, len_s;
    logic [AW:0]   err_r, err_s;
    logic [AW-1:0] fidx_r, fidx_s;
    logic [W-1:0]  fval_r, fval_s, ui_r, ui_s;
    logic          done_r, done_s, pass_r, pass_s, ena_r, rstn_r, busy_r;
    logic          idle_s, accept_s, mism_s, pipe_valid_s;
    logic [AW-1:0] pipe_idx_s;

    assign idle_s   = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign accept_s = idle_s && start;

    // Vector memory: writable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (cfg_we && idle_s) begin
            stim_mem[cfg_addr] <= cfg_stim;
            exp_mem[cfg_addr]  <= cfg_exp;
            mask_mem[cfg_addr] <= cfg_mask;
        end
    end

    simplez_harness_pipe #(.LAT(LAT), .AW(AW)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state_r == ST_RUN),
        .in_idx    (idx_r[AW-1:0]),
        .out_valid (pipe_valid_s),
        .out_idx   (pipe_idx_s)
    );

    assign mism_s = pipe_valid_s &&
                    (((dut.dut_uo ^ exp_mem[pipe_idx_s]) & mask_mem[pipe_idx_s]) != '0);

    // Next-state, counters and result bookkeeping.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        len_s   = len_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_DUTRST;
                    cnt_s   = '0;
                    len_s   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DUTRST: begin
                if (cnt_r == CW'(RST_CYC - 1)) begin
                    cnt_s   = '0;
                    idx_s   = '0;
                    state_s = (len_r == '0) ? ST_DONE : ST_RUN;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_RUN: begin
                if (idx_r == len_r - (AW+1)'(1)) begin
                    state_s = ST_DRAIN;
                    cnt_s   = '0;
                end else begin
                    idx_s = idx_r + (AW+1)'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_r == CW'(LAT - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: state_s = ST_IDLE;
        endcase

        err_s  = err_r;
        fidx_s = fidx_r;
        fval_s = fval_r;
        done_s = done_r;
        pass_s = pass_r;
        if (accept_s) begin
            err_s  = '0;
            fidx_s = '0;
            fval_s = '0;
            done_s = 1'b0;
            pass_s = 1'b0;
        end else if (mism_s) begin
            if (err_r != '1) err_s = err_r + (AW+1)'(1);
            else             err_s = err_r;
            if (err_r == '0) begin
                fidx_s = pipe_idx_s;
                fval_s = dut.dut_uo;
            end else begin
                fidx_s = fidx_r;
            end
        end else begin
            err_s = err_r;
        end
        // The last compare lands on the same edge as entry to DONE.
        if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
            done_s = 1'b1;
            pass_s = (err_s == '0);
        end else begin
            done_s = done_s;
        end

        ui_s = (state_s == ST_RUN) ? stim_mem[idx_s[AW-1:0]] : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            len_r   <= '0;
            err_r   <= '0;
            fidx_r  <= '0;
            fval_r  <= '0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            ui_r    <= '0;
            ena_r   <= 1'b0;
            rstn_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            len_r   <= len_s;
            err_r   <= err_s;
            fidx_r  <= fidx_s;
            fval_r  <= fval_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            ui_r    <= ui_s;
            ena_r   <= is_busy(state_s);
            rstn_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            busy_r  <= is_busy(state_s);
        end
    end

    assign dut.dut_ui    = ui_r;
    assign dut.dut_ena   = ena_r;
    assign dut.dut_rst_n = rstn_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign first_err_idx = fidx_r;
    assign first_err_val = fval_r;
endmodule

// File: doc/simplez_trace_harness.md
SIMPLEZ_TRACE_HARNESS -- requirements
Module: simplez_trace_harness

Interface
REQ-001 Parameter W, default 8: width of DUT input and output buses.
REQ-002 Parameter DEPTH, default 16, power of two >= 2: vector memory entries; AW = log2(DEPTH).
REQ-003 Parameter LAT, default 1, range 1..4: cycles from driving dut_ui to sampling dut_uo.
REQ-004 Parameter RST_CYC, default 4, >= 1: DUT reset hold cycles before playback.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 cfg_we  in  1  write strobe for vector memory.
REQ-008 cfg_addr  in  AW  write index.
REQ-009 cfg_stim / cfg_exp / cfg_mask  in  W each  stimulus, expected output, compare mask (1 = compare bit).
REQ-010 start  in  1  single-cycle run request.
REQ-011 len  in  AW+1  number of vectors to play.
REQ-012 dut_ui  out  W  stimulus to DUT.
REQ-013 dut_ena  out  1  DUT enable.
REQ-014 dut_rst_n  out  1  DUT active-low reset.
REQ-015 dut_uo  in  W  DUT response.
REQ-016 busy  out  1  run in progress.
REQ-017 done  out  1  run finished, sticky until next accepted start.
REQ-018 pass  out  1  valid when done; 1 = zero mismatches.
REQ-019 err_count  out  AW+1  mismatch count, saturating.
REQ-020 first_err_idx  out  AW / first_err_val  out  W  index and raw dut_uo of first mismatch.

Function
REQ-021 FSM states IDLE, DUTRST, RUN, DRAIN, DONE; DONE behaves as IDLE except done = 1.
REQ-022 cfg_we SHALL write all three arrays at cfg_addr in IDLE/DONE only; writes while busy are ignored.
REQ-023 start in IDLE/DONE SHALL latch min(len, DEPTH), clear done, err_count, first_err_* and pass, enter DUTRST; start while busy is ignored.
REQ-024 start and cfg_we in the same cycle: write completes; the run uses the written value.
REQ-025 DUTRST: dut_rst_n = 0, dut_ena = 1, dut_ui = 0 for exactly RST_CYC cycles, then RUN.
REQ-026 RUN: dut_rst_n = 1; vector i drives dut_ui for exactly one cycle, i = 0..len-1 consecutively.
REQ-027 Response for vector i SHALL be sampled LAT cycles after dut_ui first shows stim[i].
REQ-028 Mismatch iff ((dut_uo XOR exp[i]) AND mask[i]) != 0.
REQ-029 Each mismatch increments err_count, saturating at 2^(AW+1)-1; first mismatch alone loads first_err_idx/first_err_val.
REQ-030 After last vector: DRAIN holds dut_ui at 0 for LAT cycles until all samples compared, then DONE.
REQ-031 Entering DONE sets done = 1, pass = (err_count == 0); busy = 1 exactly in DUTRST, RUN, DRAIN.
REQ-032 len = 0: DUTRST then directly DONE with pass = 1, no samples.
REQ-033 Mask 0: vector always passes.

Reset
REQ-034 rst asserted at any time, including mid-run, SHALL force IDLE: dut_ui = 0, dut_ena = 0, dut_rst_n = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_err_idx = 0, first_err_val = 0, pending samples discarded.
REQ-035 Vector memory contents are not reset.

Structure
REQ-036 Shared package simplez_harness_pkg holds the FSM state typedef and default parameter constants.
REQ-037 One sub-module simplez_harness_pipe: LAT-deep valid+index delay line, async reset.
REQ-038 Memory is flop-based; no vendor macros.

Verification
REQ-039 Load 4 vectors stim = 01,02,03,04, exp = stim, mask = FF, dut_uo looped from dut_ui through LAT = 1 register, len = 4 -> done, pass = 1, err_count = 0, busy high 4+4+1 = 9 cycles.
REQ-040 Same, exp[2] = 00 -> pass = 0, err_count = 1, first_err_idx = 2, first_err_val = 03.
REQ-041 exp[1] = 00, exp[3] = 00, mask[3] = 00 -> err_count = 1, first_err_idx = 1.
REQ-042 len = 0 -> done after RST_CYC+1 cycles, pass = 1; len = 31 with DEPTH = 16 -> exactly 16 vectors driven.
REQ-043 rst pulsed during RUN at vector 2 -> next cycle all outputs at reset values; subsequent start runs cleanly to pass = 1.
REQ-044 start and cfg_we while busy -> ignored: vector count, memory contents and results unchanged.
